genius_seq_store: RTL and testbench
===================================

Name: genius_seq_store

Overview:
- Parametrised successor to the game's single-word enabled register: holds the Genius colour sequence as up to DEPTH symbols of W bits each.
- The game controller appends one symbol per round.
- The block plays the sequence back one symbol per step to drive the LEDs.
- It checks player presses against the stored sequence and reports match, mismatch and round-complete.
- Sits between the round controller FSM and the LED/button interface.

Parameters:
- W, 4, symbol width (one-hot colour).
- DEPTH, 16, maximum sequence length (≥2).
- LW, 5, width of the length/pointer counters; must satisfy 2^LW > DEPTH.

Ports:
- CLK  in  1  clock, rising edge.
- R  in  1  asynchronous reset, active-low.
- E  in  1  enable; when 0, all state holds and pulse outputs are 0.
- CLR  in  1  clears sequence (len=0), returns to IDLE.
- APPEND  in  1  append sym_in at index len.
- sym_in  in  W  symbol to append.
- PLAY_START  in  1  begin playback from index 0.
- RD_NEXT  in  1  advance playback pointer.
- CHK_START  in  1  begin checking from index 0.
- cmp_en  in  1  player press valid this cycle.
- cmp_sym  in  W  player's symbol.
- rd_sym  out  W  stored symbol at the pointer while in PLAY; 0 otherwise.
- rd_valid  out  1  high while in PLAY.
- rd_last  out  1  high in PLAY when ptr==len-1.
- len  out  LW  current sequence length.
- full  out  1  len==DEPTH.
- busy  out  1  state != IDLE.
- ovf  out  1  one-cycle pulse: APPEND rejected because full.
- cmp_ok  out  1  one-cycle pulse: correct press, more symbols remain.
- cmp_done  out  1  one-cycle pulse: correct press on the last symbol.
- cmp_err  out  1  one-cycle pulse: wrong press.

Behaviour:
- Reset (R=0, async): state=IDLE, len=0, ptr=0. All outputs 0. Memory contents are don't-care.
- Register updates occur only on a CLK rising edge with R=1.
- CLR: highest priority and acts even when E=0. Next state IDLE, len=0, ptr=0, all pulses 0.
- E=0 (no CLR): every register holds; ovf, cmp_ok, cmp_done and cmp_err are 0.
- States:
  - IDLE: ptr=0.
  - PLAY: rd_valid=1, rd_sym=mem[ptr] (combinational from the registered ptr), rd_last=(ptr==len-1).
  - CHECK: rd_valid=0, rd_sym=0.
- IDLE, input priority APPEND > PLAY_START > CHK_START:
  - APPEND with len<DEPTH: mem[len]<=sym_in, len<=len+1.
  - APPEND with full=1: no write; ovf pulses in the next cycle.
  - PLAY_START or CHK_START with len==0: ignored, stays IDLE.
  - Otherwise go to PLAY or CHECK with ptr=0.
  - A start asserted in the same cycle as APPEND is dropped.
- PLAY:
  - RD_NEXT with ptr<len-1: ptr<=ptr+1.
  - RD_NEXT with ptr==len-1: go to IDLE, ptr=0.
  - APPEND, PLAY_START, CHK_START and cmp_en are ignored.
- CHECK, on cmp_en:
  - cmp_sym==mem[ptr] and ptr<len-1: ptr++, cmp_ok pulses.
  - cmp_sym==mem[ptr] and ptr==len-1: go to IDLE, cmp_done pulses.
  - Mismatch: go to IDLE, cmp_err pulses.
  - APPEND, starts and RD_NEXT are ignored.
- Pulse timing: pulses are registered, high for exactly one cycle after the sampling edge, at most one of ok/done/err per cycle.
- Latency: a start sampled at edge k gives rd_valid (PLAY) or busy (CHECK) high from edge k onward. The first rd_sym is valid in that same cycle.
- Arithmetic: len saturates at DEPTH (never wraps). ptr never exceeds len-1. Comparison is exact over all W bits.

Test Plan:
- Reset: R low mid-PLAY with len=3 -> immediately len=0, busy=0, rd_valid=0, all pulses 0. After R high, PLAY_START is ignored (len=0).
- Append/full: DEPTH=4; APPEND 1,2,4,8 then a fifth APPEND 1 -> len=4, full=1, ovf high one cycle, len stays 4.
- Playback: sequence {1,2,4}; PLAY_START then RD_NEXT every cycle -> rd_sym 1,2,4; rd_last only with 4; returns to IDLE, rd_valid=0.
- Check pass: sequence {1,2,4}; CHK_START; cmp_sym 1,2,4 -> cmp_ok, cmp_ok, cmp_done; busy=0 afterwards.
- Check fail: sequence {1,2,4}; CHK_START; cmp_sym 1,8 -> cmp_ok then cmp_err, IDLE; a following APPEND 2 gives len=4.
- Gating/priority: E=0 with APPEND -> len unchanged. APPEND+PLAY_START in the same cycle -> append only, state IDLE. CLR with E=0 -> len=0.

Source files
------------

// File: rtl/genius_seq_store.sv
// Genius colour-sequence store.
// Holds up to DEPTH one-hot symbols appended by the round controller. It plays
// the sequence back one symbol per RD_NEXT to drive the LEDs, and it checks
// player presses against the stored sequence.
//
// Handshake: there is no valid/ready back-pressure. Every command input
// (APPEND, PLAY_START, RD_NEXT, CHK_START, cmp_en) is a single-cycle request
// sampled on the rising CLK edge. A command is either acted on in that cycle
// or dropped; it is never queued. rd_valid qualifies rd_sym/rd_last for the
// whole PLAY state. ovf/cmp_ok/cmp_done/cmp_err are registered one-cycle
// result pulses.
module genius_seq_store #(
  parameter int W     = 4,
  parameter int DEPTH = 16,
  parameter int LW    = 5
) (
  input  logic          CLK,
  input  logic          R,
  input  logic          E,
  input  logic          CLR,
  input  logic          APPEND,
  input  logic [W-1:0]  sym_in,
  input  logic          PLAY_START,
  input  logic          RD_NEXT,
  input  logic          CHK_START,
  input  logic          cmp_en,
  input  logic [W-1:0]  cmp_sym,
  output logic [W-1:0]  rd_sym,
  output logic          rd_valid,
  output logic          rd_last,
  output logic [LW-1:0] len,
  output logic          full,
  output logic          busy,
  output logic          ovf,
  output logic          cmp_ok,
  output logic          cmp_done,
  output logic          cmp_err,
  output logic [1:0]    dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] ptr_q, ptr_d;
  logic          ovf_q, ovf_d;
  logic          ok_q, ok_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          wr_en;
  logic [W-1:0]  cur_sym;
  logic          is_last;
  logic [W-1:0]  mem [DEPTH];

  // The pointer never exceeds len-1 < DEPTH, so the low AW bits address the array.
  assign cur_sym = mem[ptr_q[AW-1:0]];
  assign is_last = (ptr_q == len_q - LW'(1));

  // Next-state, counter and pulse decode. CLR overrides everything, including E.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    ovf_d   = 1'b0;
    ok_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    if (CLR) begin
      state_d = IDLE;
      len_d   = '0;
      ptr_d   = '0;
    end else if (E) begin
      case (state_q)
        IDLE: begin
          ptr_d = '0;
          if (APPEND) begin
            // A start in the same cycle as APPEND is dropped.
            if (len_q != DEPTH_L) begin
              wr_en = 1'b1;
              len_d = len_q + LW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else if (PLAY_START && (len_q != '0)) begin
            state_d = PLAY;
          end else if (CHK_START && (len_q != '0)) begin
            state_d = CHECK;
          end
        end
        PLAY: begin
          if (RD_NEXT) begin
            if (is_last) begin
              state_d = IDLE;
              ptr_d   = '0;
            end else begin
              ptr_d = ptr_q + LW'(1);
            end
          end
        end
        CHECK: begin
          if (cmp_en) begin
            if (cmp_sym == cur_sym) begin
              if (is_last) begin
                state_d = IDLE;
                ptr_d   = '0;
                done_d  = 1'b1;
              end else begin
                ptr_d = ptr_q + LW'(1);
                ok_d  = 1'b1;
              end
            end else begin
              state_d = IDLE;
              ptr_d   = '0;
              err_d   = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      endcase
    end
  end

  // State, counters and result pulses; async active-low reset.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      len_q   <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      ok_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      ok_q    <= ok_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Symbol storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[len_q[AW-1:0]] <= sym_in;
    end
  end

  assign rd_valid  = (state_q == PLAY);
  assign rd_sym    = rd_valid ? cur_sym : '0;
  assign rd_last   = rd_valid & is_last;
  assign len       = len_q;
  assign full      = (len_q == DEPTH_L);
  assign busy      = (state_q != IDLE);
  // Pulse outputs are forced low while the block is disabled.
  assign ovf       = ovf_q & E;
  assign cmp_ok    = ok_q & E;
  assign cmp_done  = done_q & E;
  assign cmp_err   = err_q & E;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_genius_seq_store.sv
// Testbench for genius_seq_store: directed test-plan scenarios followed by
// randomized traffic. All of it is checked against a sequence-level reference model.
module tb_genius_seq_store;

  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          CLK = 1'b0;
  logic          R, E, CLR, APPEND, PLAY_START, RD_NEXT, CHK_START, cmp_en;
  logic [W-1:0]  sym_in, cmp_sym;
  logic [W-1:0]  rd_sym;
  logic          rd_valid, rd_last, full, busy, ovf, cmp_ok, cmp_done, cmp_err;
  logic [LW-1:0] len;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: the stored sequence plus mode and position.
  logic [W-1:0] exp_q[$];
  int   m_mode;  // 0 idle, 1 playing, 2 checking
  int   m_ptr;
  logic m_ovf, m_ok, m_done, m_err;

  genius_seq_store #(.W(W), .DEPTH(DEPTH), .LW(LW)) dut (
    .CLK(CLK), .R(R), .E(E), .CLR(CLR), .APPEND(APPEND), .sym_in(sym_in),
    .PLAY_START(PLAY_START), .RD_NEXT(RD_NEXT), .CHK_START(CHK_START),
    .cmp_en(cmp_en), .cmp_sym(cmp_sym), .rd_sym(rd_sym), .rd_valid(rd_valid),
    .rd_last(rd_last), .len(len), .full(full), .busy(busy), .ovf(ovf),
    .cmp_ok(cmp_ok), .cmp_done(cmp_done), .cmp_err(cmp_err), .dbg_state(dbg_state)
  );

  // Clock generation.
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_mode = 0;
    m_ptr  = 0;
    m_ovf  = 0;
    m_ok   = 0;
    m_done = 0;
    m_err  = 0;
  endtask

  // Apply one rising edge to the model using the currently driven inputs.
  task automatic model_edge();
    logic ovf_n, ok_n, done_n, err_n;
    int   sz;
    ovf_n = 0; ok_n = 0; done_n = 0; err_n = 0;
    sz = exp_q.size();
    if (CLR) begin
      exp_q.delete();
      m_mode = 0;
      m_ptr  = 0;
    end else if (E) begin
      if (m_mode == 0) begin
        if (APPEND) begin
          if (sz < DEPTH) exp_q.push_back(sym_in);
          else ovf_n = 1;
        end else if (PLAY_START && sz > 0) begin
          m_mode = 1; m_ptr = 0;
        end else if (CHK_START && sz > 0) begin
          m_mode = 2; m_ptr = 0;
        end
      end else if (m_mode == 1) begin
        if (RD_NEXT) begin
          if (m_ptr == sz - 1) begin m_mode = 0; m_ptr = 0; end
          else m_ptr++;
        end
      end else begin
        if (cmp_en) begin
          if (cmp_sym == exp_q[m_ptr]) begin
            if (m_ptr == sz - 1) begin m_mode = 0; m_ptr = 0; done_n = 1; end
            else begin m_ptr++; ok_n = 1; end
          end else begin
            m_mode = 0; m_ptr = 0; err_n = 1;
          end
        end
      end
    end
    m_ovf = ovf_n; m_ok = ok_n; m_done = done_n; m_err = err_n;
  endtask

  task automatic check_outputs();
    int sz;
    logic [W-1:0] e_sym;
    sz    = exp_q.size();
    e_sym = (m_mode == 1) ? exp_q[m_ptr] : '0;
    check("len",      32'(len),      32'(sz));
    check("full",     32'(full),     32'(sz == DEPTH));
    check("busy",     32'(busy),     32'(m_mode != 0));
    check("rd_valid", 32'(rd_valid), 32'(m_mode == 1));
    check("rd_last",  32'(rd_last),  32'(m_mode == 1 && m_ptr == sz - 1));
    check("rd_sym",   32'(rd_sym),   32'(e_sym));
    check("ovf",      32'(ovf),      32'(m_ovf & E));
    check("cmp_ok",   32'(cmp_ok),   32'(m_ok & E));
    check("cmp_done", 32'(cmp_done), 32'(m_done & E));
    check("cmp_err",  32'(cmp_err),  32'(m_err & E));
  endtask

  // One clock: edge, model update, then sample outputs away from the edge.
  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Driver tasks.
  task automatic idle_inputs();
    E = 1; CLR = 0; APPEND = 0; PLAY_START = 0; RD_NEXT = 0; CHK_START = 0;
    cmp_en = 0; sym_in = '0; cmp_sym = '0;
  endtask

  task automatic do_clear();
    CLR = 1; tick(); CLR = 0;
  endtask

  task automatic do_append(input logic [W-1:0] s);
    APPEND = 1; sym_in = s; tick(); APPEND = 0;
  endtask

  task automatic do_press(input logic [W-1:0] s);
    cmp_en = 1; cmp_sym = s; tick(); cmp_en = 0;
  endtask

  task automatic load_124();
    do_clear();
    do_append(4'd1); do_append(4'd2); do_append(4'd4);
  endtask

  initial begin
    idle_inputs();
    R = 0;
    model_reset();
    #12;
    check_outputs();
    R = 1;

    // Append until full, then one more append overflows.
    do_clear();
    do_append(4'd1); do_append(4'd2); do_append(4'd4); do_append(4'd8);
    do_append(4'd1);
    check("ovf_pulse", 32'(ovf), 32'd1);
    check("full_len",  32'(len), 32'd4);
    tick();
    check("ovf_gone",  32'(ovf), 32'd0);

    // Playback of {1,2,4}.
    load_124();
    PLAY_START = 1; tick(); PLAY_START = 0;
    check("play_first", 32'(rd_sym), 32'd1);
    RD_NEXT = 1;
    tick(); tick();
    check("play_last_sym", 32'(rd_sym),  32'd4);
    check("play_last",     32'(rd_last), 32'd1);
    tick();
    RD_NEXT = 0;
    check("play_end", 32'(rd_valid), 32'd0);

    // Successful check.
    CHK_START = 1; tick(); CHK_START = 0;
    do_press(4'd1); check("chk_ok1", 32'(cmp_ok), 32'd1);
    do_press(4'd2); check("chk_ok2", 32'(cmp_ok), 32'd1);
    do_press(4'd4); check("chk_done", 32'(cmp_done), 32'd1);
    check("chk_idle", 32'(busy), 32'd0);

    // Failing check, then append still works.
    load_124();
    CHK_START = 1; tick(); CHK_START = 0;
    do_press(4'd1);
    do_press(4'd8); check("chk_err", 32'(cmp_err), 32'd1);
    do_append(4'd2); check("len_after_err", 32'(len), 32'd4);

    // Enable gating and start/append priority.
    load_124();
    E = 0; do_append(4'd8); check("gated_len", 32'(len), 32'd3);
    E = 1;
    APPEND = 1; PLAY_START = 1; sym_in = 4'd8; tick(); APPEND = 0; PLAY_START = 0;
    check("prio_busy", 32'(busy), 32'd0);
    E = 0; do_clear(); check("clr_gated", 32'(len), 32'd0);
    E = 1;

    // Asynchronous reset in the middle of playback.
    load_124();
    PLAY_START = 1; tick(); PLAY_START = 0;
    RD_NEXT = 1; tick(); RD_NEXT = 0;
    R = 0;
    #2;
    model_reset();
    check_outputs();
    @(negedge CLK);
    R = 1;
    PLAY_START = 1; tick(); PLAY_START = 0;
    check("start_empty", 32'(busy), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      E          = ($urandom_range(0, 9) != 0);
      CLR        = ($urandom_range(0, 59) == 0);
      APPEND     = ($urandom_range(0, 3) == 0);
      sym_in     = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 15))
                                               : W'(1 << $urandom_range(0, 3));
      PLAY_START = ($urandom_range(0, 3) == 0);
      CHK_START  = ($urandom_range(0, 3) == 0);
      RD_NEXT    = ($urandom_range(0, 1) == 0);
      cmp_en     = ($urandom_range(0, 1) == 0);
      if (m_mode == 2 && $urandom_range(0, 3) != 0) cmp_sym = exp_q[m_ptr];
      else cmp_sym = W'($urandom_range(0, 15));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
